// File: rtl/gen1_descrambler_pkg.sv
// Shared constants, lock state type and per-byte descramble helper for the Gen1/Gen2 RX
// descrambler.
package gen1_descrambler_pkg;

  localparam logic [7:0]  K28_5_COM      = 8'hBC;
  localparam logic [7:0]  K28_0_SKP      = 8'h1C;
  localparam logic [15:0] GEN1_LFSR_SEED = 16'hFFFF;
  // Galois feedback mask for x^16+x^5+x^4+x^3+1: the shifted-out MSB feeds bits 5,4,3,0
  localparam logic [15:0] GEN1_LFSR_TAPS = 16'h0039;

  typedef enum logic {StUnlocked, StLocked} lock_state_e;

  typedef struct packed {
    logic [15:0] lfsr;
    logic        lock;
    logic        com;
    logic        k;
    logic [7:0]  data;
  } byte_res_t;

  // Handles one byte lane. lfsr_step and key come from a byte step of lfsr_cur.
  function automatic byte_res_t byte_stage(input logic        in_range,
                                           input logic        k,
                                           input logic        ts,
                                           input logic        en,
                                           input logic        lock,
                                           input logic [7:0]  b,
                                           input logic [7:0]  key,
                                           input logic [15:0] lfsr_cur,
                                           input logic [15:0] lfsr_step,
                                           input logic [15:0] seed);
    byte_res_t r;
    r.lfsr = lfsr_cur;
    r.lock = lock;
    r.com  = 1'b0;
    r.k    = 1'b0;
    r.data = 8'h00;
    if (in_range) begin
      r.k    = k;
      r.data = b;
      if (k && b == K28_5_COM) begin
        r.lfsr = seed;
        r.lock = 1'b1;
        r.com  = 1'b1;
      end else if (!(k && b == K28_0_SKP)) begin
        r.lfsr = lfsr_step;
        if (!k && !ts && en && lock) r.data = b ^ key;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/gen1_descrambler_if.sv
// Beat-level bus between the ordered-set detector, the descrambler and the RX link layer.
interface gen1_descrambler_if;

  logic        valid_i;
  logic [3:0]  datak_i;
  logic [3:0]  training_sequence_i;
  logic [1:0]  data_len_i;
  logic [31:0] indata_i;
  logic        descramble_enable_i;
  logic        valid_o;
  logic [3:0]  datak_o;
  logic [1:0]  data_len_o;
  logic [31:0] descrambled_data_o;
  logic        lock_o;

  modport master (
    output valid_i, datak_i, training_sequence_i, data_len_i, indata_i, descramble_enable_i,
    input  valid_o, datak_o, data_len_o, descrambled_data_o, lock_o
  );

  modport slave (
    input  valid_i, datak_i, training_sequence_i, data_len_i, indata_i, descramble_enable_i,
    output valid_o, datak_o, data_len_o, descrambled_data_o, lock_o
  );

endinterface

// File: rtl/gen1_lfsr_byte_step.sv
// One byte of the Gen1 scrambler LFSR: key bit n is the MSB before the n-th shift.
module gen1_lfsr_byte_step
  import gen1_descrambler_pkg::*;
(
  input  logic [15:0] lfsr_in,
  output logic [7:0]  key,
  output logic [15:0] lfsr_out
);

  logic [15:0] shift;

  always_comb begin
    shift = lfsr_in;
    key   = 8'h00;
    for (int i = 0; i < 8; i++) begin
      key[i] = shift[15];
      shift  = {shift[14:0], 1'b0} ^ (shift[15] ? GEN1_LFSR_TAPS : 16'h0000);
    end
    lfsr_out = shift;
  end

endmodule

// File: rtl/gen1_descrambler.sv
// Gen1/Gen2 RX descrambler, 4 bytes per clock: COM resync, SKP skip, lock tracking, 1-cycle
// registered latency.
module gen1_descrambler
  import gen1_descrambler_pkg::*;
#(
  parameter int unsigned LOCK_TIMEOUT = 1024,
  parameter logic [15:0] LFSR_SEED    = GEN1_LFSR_SEED
) (
  input logic               clk_i,
  input logic               rst_i,
  gen1_descrambler_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(LOCK_TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(LOCK_TIMEOUT - 1);

  lock_state_e     state_q;
  logic [CntW-1:0] cnt_q;
  logic [15:0]     lfsr_q;
  logic            valid_q;
  logic [3:0]      datak_q;
  logic [1:0]      len_q;
  logic [31:0]     data_q;

  logic [3:0]  in_range;
  logic        locked;
  logic        any_com;
  logic [7:0]  key0, key1, key2, key3;
  logic [15:0] step0, step1, step2, step3;
  byte_res_t   res0, res1, res2, res3;

  assign in_range = {bus.data_len_i == 2'd3, bus.data_len_i >= 2'd2,
                     bus.data_len_i != 2'd0, 1'b1};
  assign locked   = (state_q == StLocked);

  // Lanes chain LFSR and lock through distinct signals so each byte sees its predecessors.
  gen1_lfsr_byte_step u_step0 (.lfsr_in(lfsr_q), .key(key0), .lfsr_out(step0));
  assign res0 = byte_stage(in_range[0], bus.datak_i[0], bus.training_sequence_i[0],
                           bus.descramble_enable_i, locked, bus.indata_i[7:0], key0,
                           lfsr_q, step0, LFSR_SEED);

  gen1_lfsr_byte_step u_step1 (.lfsr_in(res0.lfsr), .key(key1), .lfsr_out(step1));
  assign res1 = byte_stage(in_range[1], bus.datak_i[1], bus.training_sequence_i[1],
                           bus.descramble_enable_i, res0.lock, bus.indata_i[15:8], key1,
                           res0.lfsr, step1, LFSR_SEED);

  gen1_lfsr_byte_step u_step2 (.lfsr_in(res1.lfsr), .key(key2), .lfsr_out(step2));
  assign res2 = byte_stage(in_range[2], bus.datak_i[2], bus.training_sequence_i[2],
                           bus.descramble_enable_i, res1.lock, bus.indata_i[23:16], key2,
                           res1.lfsr, step2, LFSR_SEED);

  gen1_lfsr_byte_step u_step3 (.lfsr_in(res2.lfsr), .key(key3), .lfsr_out(step3));
  assign res3 = byte_stage(in_range[3], bus.datak_i[3], bus.training_sequence_i[3],
                           bus.descramble_enable_i, res2.lock, bus.indata_i[31:24], key3,
                           res2.lfsr, step3, LFSR_SEED);

  assign any_com = res0.com | res1.com | res2.com | res3.com;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StUnlocked;
      cnt_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      valid_q <= 1'b0;
      datak_q <= 4'h0;
      len_q   <= 2'd0;
      data_q  <= 32'h0;
    end else begin
      valid_q <= bus.valid_i;
      if (bus.valid_i) begin
        lfsr_q  <= res3.lfsr;
        data_q  <= {res3.data, res2.data, res1.data, res0.data};
        datak_q <= {res3.k, res2.k, res1.k, res0.k};
        len_q   <= bus.data_len_i;
        // A COM in the beat wins over a timeout reached in the same beat
        if (any_com) begin
          state_q <= StLocked;
          cnt_q   <= '0;
        end else begin
          if (cnt_q != CntMax) cnt_q <= cnt_q + CntW'(1);
          if (state_q == StLocked && cnt_q == CntLast) state_q <= StUnlocked;
        end
      end
    end
  end

  assign bus.valid_o            = valid_q;
  assign bus.datak_o            = datak_q;
  assign bus.data_len_o         = len_q;
  assign bus.descrambled_data_o = data_q;
  assign bus.lock_o             = locked;

endmodule

// File: tb/tb_gen1_descrambler.sv
// Directed bench for gen1_descrambler; expected bytes use the Gen1 key sequence after seed FFFF:
// FF 17 C0 14 B2 E7 02 82 72 6E 28 A6 BE 6D BF 8D BE 40.
module tb_gen1_descrambler;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gen1_descrambler_if bus ();

  gen1_descrambler #(.LOCK_TIMEOUT(16)) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        v;
    logic        en;
    logic [3:0]  k;
    logic [3:0]  ts;
    logic [1:0]  len;
    logic [31:0] d;
    logic        ev;
    logic [31:0] ed;
    logic [3:0]  ek;
    logic [1:0]  elen;
    logic        elock;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic en, input logic [3:0] k, input logic [3:0] ts,
                       input logic [1:0] len, input logic [31:0] d);
    bus.valid_i             = v;
    bus.descramble_enable_i = en;
    bus.datak_i             = k;
    bus.training_sequence_i = ts;
    bus.data_len_i          = len;
    bus.indata_i            = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string tag, input logic v, input logic [31:0] d,
                            input logic [3:0] k, input logic [1:0] len, input logic lock);
    check({tag, ".valid"}, 32'(bus.valid_o), 32'(v));
    check({tag, ".data"}, bus.descrambled_data_o, d);
    check({tag, ".datak"}, 32'(bus.datak_o), 32'(k));
    check({tag, ".len"}, 32'(bus.data_len_o), 32'(len));
    check({tag, ".lock"}, 32'(bus.lock_o), 32'(lock));
  endtask

  task automatic skp_beat(input string tag, input logic exp_lock);
    drive(1'b1, 1'b1, 4'b0001, 4'b0000, 2'd0, 32'h0000001C);
    check_beat(tag, 1'b1, 32'h0000001C, 4'b0001, 2'd0, exp_lock);
  endtask

  initial begin
    // v  en  k        ts       len    indata         ev    expected data  ek       elen   elock
    vecs[0] = '{1'b1, 1'b1, 4'b0001, 4'b0000, 2'd3, 32'hC017FFBC, 1'b1, 32'h000000BC, 4'b0001, 2'd3, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 2'd3, 32'h46D49005, 1'b1, 32'h44332211, 4'b0000, 2'd3, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 4'b0010, 4'b0000, 2'd3, 32'h6ED81CD7, 1'b1, 32'h00AA1C55, 4'b0010, 2'd3, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 4'b1100, 4'b0000, 2'd1, 32'hBCBCA429, 1'b1, 32'h00000201, 4'b0000, 2'd1, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 4'b1111, 4'b1111, 2'd2, 32'hDEADBEEF, 1'b0, 32'h00000201, 4'b0000, 2'd1, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 2'd0, 32'h123456BE, 1'b1, 32'h00000000, 4'b0000, 2'd0, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 2'd0, 32'h000000A5, 1'b1, 32'h000000A5, 4'b0000, 2'd0, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 2'd1, 32'h00008DBF, 1'b1, 32'h00000000, 4'b0000, 2'd1, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 4'b0000, 4'b0001, 2'd1, 32'h0000414A, 1'b1, 32'h0000014A, 4'b0000, 2'd1, 1'b1};
    vecs[9] = '{1'b1, 1'b1, 4'b0101, 4'b0000, 2'd3, 32'hDFBCEFBC, 1'b1, 32'h20BC10BC, 4'b0101, 2'd3, 1'b1};

    bus.valid_i             = 1'b0;
    bus.descramble_enable_i = 1'b1;
    bus.datak_i             = 4'h0;
    bus.training_sequence_i = 4'h0;
    bus.data_len_i          = 2'd0;
    bus.indata_i            = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check_beat("reset", 1'b0, 32'h0, 4'h0, 2'd0, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].v, vecs[i].en, vecs[i].k, vecs[i].ts, vecs[i].len, vecs[i].d);
      check_beat($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ek, vecs[i].elen,
                 vecs[i].elock);
    end

    // 16 COM-free beats after the last COM drop lock on the 16th
    for (int i = 1; i <= 16; i++) skp_beat($sformatf("to_skp%0d", i), i < 16);
    drive(1'b1, 1'b1, 4'b0000, 4'b0000, 2'd0, 32'h00000033);
    check_beat("raw_unlocked", 1'b1, 32'h00000033, 4'b0000, 2'd0, 1'b0);

    // Byte before the COM stays raw, byte after it is descrambled with the seed key
    drive(1'b1, 1'b1, 4'b0010, 4'b0000, 2'd2, 32'h00A5BC77);
    check_beat("relock_mid", 1'b1, 32'h005ABC77, 4'b0010, 2'd2, 1'b1);

    // COM arriving on the timeout beat keeps lock
    for (int i = 1; i <= 15; i++) skp_beat($sformatf("pre_com_skp%0d", i), 1'b1);
    drive(1'b1, 1'b1, 4'b0001, 4'b0000, 2'd0, 32'h000000BC);
    check_beat("com_at_timeout", 1'b1, 32'h000000BC, 4'b0001, 2'd0, 1'b1);
    skp_beat("hold_lock", 1'b1);

    // Asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    check_beat("async_rst", 1'b0, 32'h0, 4'h0, 2'd0, 1'b0);
    bus.valid_i = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    drive(1'b1, 1'b1, 4'b0000, 4'b0000, 2'd0, 32'h00000042);
    check_beat("post_rst_raw", 1'b1, 32'h00000042, 4'b0000, 2'd0, 1'b0);
    drive(1'b1, 1'b1, 4'b0001, 4'b0000, 2'd1, 32'h000066BC);
    check_beat("post_rst_com", 1'b1, 32'h000099BC, 4'b0001, 2'd1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
